// File: rtl/bch_decode_scheduler_pkg.sv
// Shared definitions for the BCH decode scheduler.
//   - Controller state encoding.
//   - Default codeword/data widths of the BCH(15,5,t=3) decoder configuration.
package bch_decode_scheduler_pkg;

  // Controller states: IDLE -> ARM -> RUN -> DONE -> IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // BCH(15,5,t=3): codeword width N and data width K
  localparam int BCH_N = 15;
  localparam int BCH_K = 5;

endpackage

// File: rtl/bch_decode_scheduler_rr_arbiter_onehot.sv
// One-hot round-robin arbiter (purely combinational).
// The search starts one position above the last winner and wraps, so the
// previous owner gets lowest priority on the next pick.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the previous winner
//   grant - one-hot winner, zero when no request is set
//   idx   - binary index of the winner (0 when no request is set)
//   valid - at least one request was set
module rr_arbiter_onehot #(
  parameter int C_REQ = 4,
  parameter int PTR_W = (C_REQ > 1) ? $clog2(C_REQ) : 1
) (
  input  logic [C_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [C_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // Visit ptr+1, ptr+2, ... ptr+C_REQ (= ptr itself last), first hit wins
    for (int k = 1; k <= C_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % C_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/bch_decode_scheduler.sv
// Shares one BCH decoder between C_REQ requesters.
// A round-robin pick latches the winner's codeword, the decoder is driven
// through an en-only ARM cycle and then en+start until it reports ready,
// and the corrected word is returned with a one-cycle ack. A watchdog ends
// a decode that never becomes ready and flags it with O_err.
// Ports:
//   I_clk, I_rst_n     - clock, asynchronous active-low reset
//   I_req, I_data      - per-requester request level and codeword
//   O_grant, O_ack     - one-hot owner of the job, one-cycle completion pulse
//   O_data, O_err      - corrected data (held until next completion), timeout flag
//   O_busy             - controller not idle
//   O_dec_en, O_dec_start, O_dec_data - decoder control and codeword
//   I_dec_data, I_dec_ready           - decoder result and ready
module bch_decode_scheduler
  import bch_decode_scheduler_pkg::*;
#(
  parameter int C_REQ     = 4,
  parameter int C_N       = BCH_N,
  parameter int C_K       = BCH_K,
  parameter int C_TIMEOUT = 1023,
  // 2**C_TO_W must exceed C_TIMEOUT or the watchdog can never fire
  parameter int C_TO_W    = 10
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic [C_REQ-1:0]     I_req,
  input  logic [C_REQ*C_N-1:0] I_data,
  output logic [C_REQ-1:0]     O_grant,
  output logic [C_REQ-1:0]     O_ack,
  output logic [C_K-1:0]       O_data,
  output logic                 O_err,
  output logic                 O_busy,
  output logic                 O_dec_en,
  output logic                 O_dec_start,
  output logic [C_N-1:0]       O_dec_data,
  input  logic [C_K-1:0]       I_dec_data,
  input  logic                 I_dec_ready
);

  localparam int PTR_W = (C_REQ > 1) ? $clog2(C_REQ) : 1;

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [C_TO_W-1:0] to_cnt;
  logic [C_N-1:0]    codeword;

  logic [C_REQ-1:0]  pick;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;

  rr_arbiter_onehot #(
    .C_REQ (C_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (I_req),
    .ptr   (ptr),
    .grant (pick),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // The decoder re-reads its codeword at completion, so it is fed from the
  // latched register and never from the live request bus.
  assign O_dec_data = codeword;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= ST_IDLE;
      ptr         <= PTR_W'(C_REQ - 1);
      to_cnt      <= '0;
      codeword    <= '0;
      O_grant     <= '0;
      O_ack       <= '0;
      O_data      <= '0;
      O_err       <= 1'b0;
      O_busy      <= 1'b0;
      O_dec_en    <= 1'b0;
      O_dec_start <= 1'b0;
    end else begin
      O_ack <= '0;
      case (state)
        ST_IDLE: begin
          // At least one en-low cycle here resets the decoder's sticky ready
          O_err       <= 1'b0;
          O_dec_en    <= 1'b0;
          O_dec_start <= 1'b0;
          if (pick_vld) begin
            codeword <= I_data[pick_idx*C_N +: C_N];
            O_grant  <= pick;
            ptr      <= pick_idx;
            O_busy   <= 1'b1;
            O_dec_en <= 1'b1;
            state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          // Start was low for one enabled cycle, so this rise is a clean edge
          O_dec_start <= 1'b1;
          state       <= ST_RUN;
        end
        ST_RUN: begin
          // Ready takes precedence over an expiring watchdog
          if (I_dec_ready) begin
            O_data      <= I_dec_data;
            O_err       <= 1'b0;
            O_ack       <= O_grant;
            O_dec_en    <= 1'b0;
            O_dec_start <= 1'b0;
            state       <= ST_DONE;
          end else if (to_cnt == C_TO_W'(C_TIMEOUT)) begin
            O_data      <= '0;
            O_err       <= 1'b1;
            O_ack       <= O_grant;
            O_dec_en    <= 1'b0;
            O_dec_start <= 1'b0;
            state       <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          O_grant <= '0;
          O_err   <= 1'b0;
          O_busy  <= 1'b0;
          to_cnt  <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
